cache_miss_controller: RTL and testbench

Sequencing controller for the direct-mapped, one-word-per-line, write-back data cache. It owns the line store (tag/data/valid/dirty). It resolves CPU requests as hit or miss. On a miss it runs write-back and refill transactions over a req/ack handshake to the backing data memory. It also performs a full write-back flush on command. It sits between the pipeline memory stage and data memory.

---
 rtl/cache_pkg.sv | 25 ++
 rtl/cache_line_store.sv | 48 ++++
 rtl/cache_miss_controller.sv | 213 +++++++++++++++++++++
 tb/tb_cache_miss_controller.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared types and constants for the direct-mapped write-back data cache.
package cache_pkg;

  localparam int BYTE_OFFSET_WIDTH = 2;

  typedef struct packed {
    logic valid;
    logic dirty;
  } cache_flags_t;

  typedef enum logic [2:0] {
    IDLE,
    COMPARE,
    WRITEBACK,
    REFILL,
    FLUSH_SCAN,
    FLUSH_WB
  } ctrl_state_t;

  typedef enum logic {
    MEM_READ  = 1'b0,
    MEM_WRITE = 1'b1
  } mem_op_t;

endpackage

// File: rtl/cache_line_store.sv
// Line store: tag/data arrays plus valid/dirty flags; async read, sync write.
module cache_line_store
  import cache_pkg::*;
#(
  parameter int SET_WIDTH  = 3,
  parameter int TAG_WIDTH  = 11,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [SET_WIDTH-1:0]  rd_set_i,
  output logic [TAG_WIDTH-1:0]  rd_tag_o,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output cache_flags_t          rd_flags_o,
  input  logic                  we_i,
  input  logic [SET_WIDTH-1:0]  wr_set_i,
  input  logic [TAG_WIDTH-1:0]  wr_tag_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  cache_flags_t          wr_flags_i
);

  localparam int unsigned LINES = 1 << SET_WIDTH;

  logic [DATA_WIDTH-1:0] data_mem  [LINES];
  logic [TAG_WIDTH-1:0]  tag_mem   [LINES];
  cache_flags_t          flags_mem [LINES];

  assign rd_tag_o   = tag_mem[rd_set_i];
  assign rd_data_o  = data_mem[rd_set_i];
  assign rd_flags_o = flags_mem[rd_set_i];

  // Only the flags need reset; tag/data are meaningless while invalid.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < LINES; i++) flags_mem[i] <= '0;
    end else if (we_i) begin
      flags_mem[wr_set_i] <= wr_flags_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      data_mem[wr_set_i] <= wr_data_i;
      tag_mem[wr_set_i]  <= wr_tag_i;
    end
  end

endmodule

// File: rtl/cache_miss_controller.sv
// Hit/miss sequencing, write-back/refill handshake and full flush for the
// direct-mapped one-word-per-line write-back data cache.
module cache_miss_controller
  import cache_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 16,
  parameter int DATA_WIDTH    = 32,
  parameter int SET_WIDTH     = 3
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     cpu_req_i,
  input  logic                     cpu_wen_i,
  input  logic [ADDRESS_WIDTH-1:0] cpu_addr_i,
  input  logic [DATA_WIDTH-1:0]    cpu_wdata_i,
  output logic [DATA_WIDTH-1:0]    cpu_rdata_o,
  output logic                     cpu_ready_o,
  input  logic                     flush_i,
  output logic                     flush_done_o,
  output logic                     mem_req_o,
  output logic                     mem_wen_o,
  output logic [ADDRESS_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0]    mem_wdata_o,
  input  logic [DATA_WIDTH-1:0]    mem_rdata_i,
  input  logic                     mem_ack_i
);

  localparam int TAG_WIDTH = ADDRESS_WIDTH - SET_WIDTH - BYTE_OFFSET_WIDTH;
  localparam logic [SET_WIDTH-1:0] LAST_SET = '1;
  localparam logic [BYTE_OFFSET_WIDTH-1:0] WORD_ALIGN = '0;

  ctrl_state_t           state;
  logic [TAG_WIDTH-1:0]  req_tag;
  logic [SET_WIDTH-1:0]  req_set;
  logic                  req_wen;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic [SET_WIDTH-1:0]  flush_cnt;

  logic [SET_WIDTH-1:0]     rd_set;
  logic [TAG_WIDTH-1:0]     line_tag;
  logic [DATA_WIDTH-1:0]    line_data;
  cache_flags_t             line_flags;
  logic [ADDRESS_WIDTH-1:0] line_addr;
  logic                     hit, victim_dirty, mem_done;

  logic                  we;
  logic [TAG_WIDTH-1:0]  wr_tag;
  logic [DATA_WIDTH-1:0] wr_data;
  cache_flags_t          wr_flags;

  logic unused_byte_offset;
  assign unused_byte_offset = ^cpu_addr_i[BYTE_OFFSET_WIDTH-1:0];

  assign rd_set       = (state == FLUSH_SCAN || state == FLUSH_WB) ? flush_cnt : req_set;
  assign hit          = line_flags.valid && (line_tag == req_tag);
  assign victim_dirty = line_flags.valid && line_flags.dirty;
  assign line_addr    = {line_tag, rd_set, WORD_ALIGN};
  assign mem_done     = mem_req_o && mem_ack_i;

  cache_line_store #(
    .SET_WIDTH (SET_WIDTH),
    .TAG_WIDTH (TAG_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_store (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .rd_set_i  (rd_set),
    .rd_tag_o  (line_tag),
    .rd_data_o (line_data),
    .rd_flags_o(line_flags),
    .we_i      (we),
    .wr_set_i  (rd_set),
    .wr_tag_i  (wr_tag),
    .wr_data_i (wr_data),
    .wr_flags_i(wr_flags)
  );

  // Every store update rewrites the whole line, defaulting to its current contents.
  always_comb begin
    we       = 1'b0;
    wr_tag   = line_tag;
    wr_data  = line_data;
    wr_flags = line_flags;
    unique case (state)
      COMPARE: begin
        if (req_wen && (hit || !victim_dirty)) begin
          we       = 1'b1;
          wr_tag   = req_tag;
          wr_data  = req_wdata;
          wr_flags = '{valid: 1'b1, dirty: 1'b1};
        end
      end
      WRITEBACK, FLUSH_WB: begin
        if (mem_done) begin
          we             = 1'b1;
          wr_flags.dirty = 1'b0;
        end
      end
      REFILL: begin
        if (mem_done) begin
          we       = 1'b1;
          wr_tag   = req_tag;
          wr_data  = mem_rdata_i;
          wr_flags = '{valid: 1'b1, dirty: 1'b0};
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state        <= IDLE;
      req_tag      <= '0;
      req_set      <= '0;
      req_wen      <= 1'b0;
      req_wdata    <= '0;
      flush_cnt    <= '0;
      cpu_ready_o  <= 1'b0;
      cpu_rdata_o  <= '0;
      flush_done_o <= 1'b0;
      mem_req_o    <= 1'b0;
      mem_wen_o    <= 1'b0;
      mem_addr_o   <= '0;
      mem_wdata_o  <= '0;
    end else begin
      cpu_ready_o  <= 1'b0;
      flush_done_o <= 1'b0;
      unique case (state)
        IDLE: begin
          if (flush_i) begin
            flush_cnt <= '0;
            state     <= FLUSH_SCAN;
          end else if (cpu_req_i) begin
            req_tag   <= cpu_addr_i[ADDRESS_WIDTH-1 -: TAG_WIDTH];
            req_set   <= cpu_addr_i[SET_WIDTH+BYTE_OFFSET_WIDTH-1 : BYTE_OFFSET_WIDTH];
            req_wen   <= cpu_wen_i;
            req_wdata <= cpu_wdata_i;
            state     <= COMPARE;
          end
        end
        COMPARE: begin
          if (hit) begin
            cpu_ready_o <= 1'b1;
            if (!req_wen) cpu_rdata_o <= line_data;
            state <= IDLE;
          end else if (victim_dirty) begin
            state <= WRITEBACK;
          end else if (req_wen) begin
            cpu_ready_o <= 1'b1;
            state       <= IDLE;
          end else begin
            state <= REFILL;
          end
        end
        // Request is raised on the first cycle in a memory state, so leaving
        // one state for another always yields an idle cycle on mem_req_o.
        WRITEBACK: begin
          if (!mem_req_o) begin
            mem_req_o   <= 1'b1;
            mem_wen_o   <= MEM_WRITE;
            mem_addr_o  <= line_addr;
            mem_wdata_o <= line_data;
          end else if (mem_ack_i) begin
            mem_req_o <= 1'b0;
            state     <= req_wen ? COMPARE : REFILL;
          end
        end
        REFILL: begin
          if (!mem_req_o) begin
            mem_req_o  <= 1'b1;
            mem_wen_o  <= MEM_READ;
            mem_addr_o <= {req_tag, req_set, WORD_ALIGN};
          end else if (mem_ack_i) begin
            mem_req_o <= 1'b0;
            state     <= COMPARE;
          end
        end
        FLUSH_SCAN: begin
          if (victim_dirty) begin
            state <= FLUSH_WB;
          end else if (flush_cnt == LAST_SET) begin
            flush_done_o <= 1'b1;
            flush_cnt    <= '0;
            state        <= IDLE;
          end else begin
            flush_cnt <= flush_cnt + 1'b1;
          end
        end
        FLUSH_WB: begin
          if (!mem_req_o) begin
            mem_req_o   <= 1'b1;
            mem_wen_o   <= MEM_WRITE;
            mem_addr_o  <= line_addr;
            mem_wdata_o <= line_data;
          end else if (mem_ack_i) begin
            mem_req_o <= 1'b0;
            if (flush_cnt == LAST_SET) begin
              flush_done_o <= 1'b1;
              flush_cnt    <= '0;
              state        <= IDLE;
            end else begin
              flush_cnt <= flush_cnt + 1'b1;
              state     <= FLUSH_SCAN;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_miss_controller.sv
// Self-checking bench: directed scenarios plus random traffic against a line-level cache model.
module tb_cache_miss_controller;

  localparam int AW = 16;
  localparam int DW = 32;
  localparam int SW = 3;
  localparam int TW = AW - SW - 2;
  localparam int NL = 1 << SW;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          cpu_req_i, cpu_wen_i, flush_i, mem_ack_i;
  logic [AW-1:0] cpu_addr_i;
  logic [DW-1:0] cpu_wdata_i, mem_rdata_i;
  logic [DW-1:0] cpu_rdata_o, mem_wdata_o;
  logic          cpu_ready_o, flush_done_o, mem_req_o, mem_wen_o;
  logic [AW-1:0] mem_addr_o;

  always #5 clk_i = ~clk_i;

  cache_miss_controller #(
    .ADDRESS_WIDTH(AW),
    .DATA_WIDTH   (DW),
    .SET_WIDTH    (SW)
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .cpu_req_i   (cpu_req_i),
    .cpu_wen_i   (cpu_wen_i),
    .cpu_addr_i  (cpu_addr_i),
    .cpu_wdata_i (cpu_wdata_i),
    .cpu_rdata_o (cpu_rdata_o),
    .cpu_ready_o (cpu_ready_o),
    .flush_i     (flush_i),
    .flush_done_o(flush_done_o),
    .mem_req_o   (mem_req_o),
    .mem_wen_o   (mem_wen_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_rdata_i (mem_rdata_i),
    .mem_ack_i   (mem_ack_i)
  );

  int checks = 0;
  int fails  = 0;

  // Reference model: the cache as plain per-line arrays, memory as a sparse map.
  logic [TW-1:0] m_tag   [NL];
  logic [DW-1:0] m_data  [NL];
  bit            m_valid [NL];
  bit            m_dirty [NL];
  logic [DW-1:0] mem [logic [AW-1:0]];

  typedef struct {
    bit            wen;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } txn_t;

  txn_t exp_q[$];
  int   ack_delay = -1;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] mem_rd(input logic [AW-1:0] a);
    if (mem.exists(a)) return mem[a];
    return {a, ~a} ^ 32'h5a5a_0f0f;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NL; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
    end
  endtask

  task automatic model_flush();
    for (int s = 0; s < NL; s++) begin
      if (m_valid[s] && m_dirty[s]) begin
        exp_q.push_back('{1'b1, {m_tag[s], SW'(s), 2'b00}, m_data[s]});
        m_dirty[s] = 1'b0;
      end
    end
  endtask

  task automatic model_access(input bit wen, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                              output logic [DW-1:0] rdata);
    int            s;
    logic [TW-1:0] t;
    logic [AW-1:0] w;
    s = int'(addr[SW+1:2]);
    t = addr[AW-1 -: TW];
    w = {addr[AW-1:2], 2'b00};
    if (!(m_valid[s] && m_tag[s] == t)) begin
      if (m_valid[s] && m_dirty[s])
        exp_q.push_back('{1'b1, {m_tag[s], SW'(s), 2'b00}, m_data[s]});
      m_tag[s]   = t;
      m_valid[s] = 1'b1;
      m_dirty[s] = 1'b0;
      if (!wen) begin
        exp_q.push_back('{1'b0, w, '0});
        m_data[s] = mem_rd(w);
      end
    end
    if (wen) begin
      m_data[s]  = wdata;
      m_dirty[s] = 1'b1;
    end
    rdata = m_data[s];
  endtask

  // Called on a negedge; returns on a negedge with the DUT idle.
  task automatic run(input bit do_flush, input bit do_req, input bit wen,
                     input logic [AW-1:0] addr, input logic [DW-1:0] wdata, input string tag);
    logic [DW-1:0] exp_rd;
    bit   done_seen, ready_seen, busy, just_acked;
    int   cyc, ready_cyc, wait_cnt, n_exp;
    txn_t cur;
    done_seen = 0; ready_seen = 0; busy = 0; just_acked = 0;
    cyc = 0; ready_cyc = -1; wait_cnt = 0; exp_rd = '0;
    exp_q.delete();
    if (do_flush) model_flush();
    if (do_req) model_access(wen, addr, wdata, exp_rd);
    n_exp = exp_q.size();
    flush_i     = do_flush;
    cpu_req_i   = do_req;
    cpu_wen_i   = wen;
    cpu_addr_i  = addr;
    cpu_wdata_i = wdata;
    while (!((!do_flush || done_seen) && (!do_req || ready_seen)) && cyc < 300) begin
      @(posedge clk_i);
      cyc++;
      @(negedge clk_i);
      if (cyc == 1) flush_i = 1'b0;
      mem_ack_i = 1'b0;
      if (just_acked) begin
        check({tag, " req_gap"}, 32'(mem_req_o), 32'd0);
        just_acked = 0;
      end else if (mem_req_o) begin
        if (!busy) begin
          check({tag, " txn_expected"}, 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) cur = exp_q.pop_front();
          else cur = '{mem_wen_o, mem_addr_o, mem_wdata_o};
          busy = 1;
          wait_cnt = (ack_delay >= 0) ? ack_delay : int'($urandom_range(0, 3));
        end
        check({tag, " mem_wen"}, 32'(mem_wen_o), 32'(cur.wen));
        check({tag, " mem_addr"}, 32'(mem_addr_o), 32'(cur.addr));
        if (cur.wen) check({tag, " mem_wdata"}, mem_wdata_o, cur.data);
        if (wait_cnt == 0) begin
          mem_ack_i = 1'b1;
          if (cur.wen) mem[cur.addr] = cur.data;
          else mem_rdata_i = mem_rd(cur.addr);
          busy = 0;
          just_acked = 1;
        end else begin
          wait_cnt--;
        end
      end else if (!busy && $urandom_range(0, 3) == 0) begin
        mem_ack_i   = 1'b1;
        mem_rdata_i = $urandom;
      end
      if (flush_done_o) begin
        check({tag, " flush_before_ready"}, 32'(ready_seen), 32'd0);
        done_seen = 1;
      end
      if (cpu_ready_o) begin
        ready_seen = 1;
        ready_cyc  = cyc;
        cpu_req_i  = 1'b0;
        if (!wen) check({tag, " rdata"}, cpu_rdata_o, exp_rd);
      end
    end
    check({tag, " completed"}, 32'((!do_flush || done_seen) && (!do_req || ready_seen)), 32'd1);
    check({tag, " all_txns"}, 32'(exp_q.size()), 32'd0);
    if (do_req && !do_flush && n_exp == 0) check({tag, " hit_latency"}, 32'(ready_cyc), 32'd2);
    flush_i   = 1'b0;
    cpu_req_i = 1'b0;
    @(posedge clk_i);
    @(negedge clk_i);
    mem_ack_i = 1'b0;
    check({tag, " ready_pulse"}, 32'(cpu_ready_o), 32'd0);
    check({tag, " done_pulse"}, 32'(flush_done_o), 32'd0);
    check({tag, " idle_req"}, 32'(mem_req_o), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [TW-1:0] rt;
    logic [AW-1:0] ra;
    int r;
    rst_ni = 1'b0;
    cpu_req_i = 0; cpu_wen_i = 0; cpu_addr_i = '0; cpu_wdata_i = '0;
    flush_i = 0; mem_ack_i = 0; mem_rdata_i = '0;
    model_reset();
    repeat (2) @(negedge clk_i);
    check("rst cpu_ready", 32'(cpu_ready_o), 32'd0);
    check("rst cpu_rdata", cpu_rdata_o, 32'd0);
    check("rst mem_req", 32'(mem_req_o), 32'd0);
    check("rst flush_done", 32'(flush_done_o), 32'd0);
    check("rst mem_addr", 32'(mem_addr_o), 32'd0);
    rst_ni = 1'b1;
    @(negedge clk_i);

    // 1: clean read miss then hit
    mem[16'h0010] = 32'hDEAD_BEEF;
    ack_delay = 3;
    run(0, 1, 0, 16'h0010, '0, "t1 miss");
    ack_delay = -1;
    run(0, 1, 0, 16'h0010, '0, "t1 hit");
    // 2: write allocate and read back
    run(0, 1, 1, 16'h0024, 32'h1234_5678, "t2 wr_alloc");
    run(0, 1, 0, 16'h0024, '0, "t2 rd");
    // 3: dirty eviction
    mem[16'h0424] = 32'hCAFE_F00D;
    run(0, 1, 0, 16'h0424, '0, "t3 evict");
    // 4: flush with sets 1 and 5 dirty
    run(0, 1, 1, 16'h0424, 32'hA5A5_0001, "t4 dirty1");
    run(0, 1, 1, 16'h0034, 32'hA5A5_0005, "t4 dirty5");
    run(1, 0, 0, '0, '0, "t4 flush");
    run(0, 1, 0, 16'h0424, '0, "t4 rd1");
    run(0, 1, 0, 16'h0034, '0, "t4 rd5");
    // 5: flush and request together
    run(0, 1, 1, 16'h0008, 32'h0BAD_CAFE, "t5 dirty");
    run(1, 1, 0, 16'h0010, '0, "t5 both");

    for (int i = 0; i < 250; i++) begin
      r  = int'($urandom_range(0, 19));
      rt = TW'($urandom_range(0, 3));
      ra = {rt, SW'($urandom_range(0, NL - 1)), 2'($urandom_range(0, 3))};
      if (r == 0) run(1, 0, 0, '0, '0, "rand flush");
      else run(r == 1, 1, 1'($urandom_range(0, 1)), ra, $urandom, "rand op");
    end

    // 6: reset while a refill is outstanding
    run(1, 0, 0, '0, '0, "t6 flush");
    run(0, 1, 0, 16'h0010, '0, "t6 prime");
    mem_ack_i = 1'b0;
    cpu_req_i = 1'b1; cpu_wen_i = 1'b0; cpu_addr_i = 16'h0410;
    for (int i = 0; i < 10 && !mem_req_o; i++) begin
      @(posedge clk_i);
      @(negedge clk_i);
    end
    check("t6 refill_issued", 32'(mem_req_o), 32'd1);
    check("t6 refill_wen", 32'(mem_wen_o), 32'd0);
    @(posedge clk_i);
    #2 rst_ni = 1'b0;
    #1;
    check("t6 req_dropped", 32'(mem_req_o), 32'd0);
    check("t6 ready_low", 32'(cpu_ready_o), 32'd0);
    cpu_req_i = 1'b0;
    model_reset();
    @(negedge clk_i);
    rst_ni = 1'b1;
    run(0, 1, 0, 16'h0010, '0, "t6 miss_after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
